// File: rtl/ex_mem_buffer.sv
// EX/MEM pipeline buffer: main register plus a one-entry skid so in_ready is a pure register output.
// Optional branch resolution from ALUResult[0] is compiled in with `define EX_MEM_BRANCH_EN.
module ex_mem_buffer #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     ALUResult,
  input  logic [DATA_WIDTH-1:0]     StoreData,
  input  logic [REG_ADDR_WIDTH-1:0] Rd,
  input  logic                      MemRead,
  input  logic                      MemWrite,
  input  logic                      RegWrite,
  input  logic                      MemtoReg,
`ifdef EX_MEM_BRANCH_EN
  input  logic                      Branch,
  input  logic [DATA_WIDTH-1:0]     BranchPC,
  output logic                      BranchTaken,
  output logic [DATA_WIDTH-1:0]     BranchTarget,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_ALUResult,
  output logic [DATA_WIDTH-1:0]     out_StoreData,
  output logic [REG_ADDR_WIDTH-1:0] out_Rd,
  output logic                      out_MemRead,
  output logic                      out_MemWrite,
  output logic                      out_RegWrite,
  output logic                      out_MemtoReg
);

  localparam int EW = 2 * DATA_WIDTH + REG_ADDR_WIDTH + 4;

  logic [EW-1:0] in_entry;
  logic [EW-1:0] main_q, main_d;
  logic [EW-1:0] skid_q, skid_d;
  logic          main_valid_q, main_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic          accept, drain;

  assign in_entry = {ALUResult, StoreData, Rd, MemRead, MemWrite, RegWrite, MemtoReg};
  assign in_ready = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign accept = in_valid & in_ready;
  assign drain  = main_valid_q & out_ready;

  assign {out_ALUResult, out_StoreData, out_Rd,
          out_MemRead, out_MemWrite, out_RegWrite, out_MemtoReg} = main_q;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      // Data registers keep stale contents; only the valid bits matter.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = accept;
        if (accept) skid_d = in_entry;
      end else begin
        main_valid_d = accept;
        if (accept) main_d = in_entry;
      end
    end else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

`ifdef EX_MEM_BRANCH_EN
  logic                  branch_taken_q, branch_taken_d;
  logic [DATA_WIDTH-1:0] branch_target_q, branch_target_d;

  // Resolution tracks the accept, so the pulse is independent of downstream stalls.
  always_comb begin
    branch_taken_d  = accept & ~flush & Branch & ALUResult[0];
    branch_target_d = branch_taken_d ? BranchPC : branch_target_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_taken_q  <= 1'b0;
      branch_target_q <= '0;
    end else begin
      branch_taken_q  <= branch_taken_d;
      branch_target_q <= branch_target_d;
    end
  end

  assign BranchTaken  = branch_taken_q;
  assign BranchTarget = branch_target_q;
`endif

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Bench for ex_mem_buffer: vector table, directed corner sequences, and random traffic
// checked against a FIFO-queue reference model.
module tb_ex_mem_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] ALUResult = '0, StoreData = '0;
  logic [4:0]  Rd = '0;
  logic        MemRead = 1'b0, MemWrite = 1'b0, RegWrite = 1'b0, MemtoReg = 1'b0;
  logic [31:0] out_ALUResult, out_StoreData;
  logic [4:0]  out_Rd;
  logic        out_MemRead, out_MemWrite, out_RegWrite, out_MemtoReg;
`ifdef EX_MEM_BRANCH_EN
  logic        Branch = 1'b0;
  logic [31:0] BranchPC = '0;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_buffer #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .ALUResult(ALUResult), .StoreData(StoreData), .Rd(Rd),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
`ifdef EX_MEM_BRANCH_EN
    .Branch(Branch), .BranchPC(BranchPC),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ALUResult(out_ALUResult), .out_StoreData(out_StoreData), .out_Rd(out_Rd),
    .out_MemRead(out_MemRead), .out_MemWrite(out_MemWrite),
    .out_RegWrite(out_RegWrite), .out_MemtoReg(out_MemtoReg)
  );

  typedef struct {
    logic        rst, fl, iv, ordy;
    logic [31:0] alu;
    logic        e_ov, e_ir, chk_alu;
    logic [31:0] e_alu;
  } vec_t;

  typedef struct {
    logic [31:0] alu, sd;
    logic [4:0]  rd;
    logic        mr, mw, rw, mtr;
  } ent_t;

  function automatic vec_t mk(logic rst, logic fl, logic iv, logic ordy, logic [31:0] alu,
                              logic e_ov, logic e_ir, logic ca, logic [31:0] e_alu);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.ordy = ordy; v.alu = alu;
    v.e_ov = e_ov; v.e_ir = e_ir; v.chk_alu = ca; v.e_alu = e_alu;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[20];
  ent_t mq[$];

  initial begin
    // Rows: inputs for one edge, then outputs expected just after it.
    tbl[0]  = mk(1, 0, 1, 0, 32'h55, 0, 1, 1, 32'h0);
    tbl[1]  = mk(1, 0, 1, 0, 32'h55, 0, 1, 1, 32'h0);
    tbl[2]  = mk(0, 0, 0, 0, 32'h00, 0, 1, 1, 32'h0);
    tbl[3]  = mk(0, 0, 1, 1, 32'h10, 1, 1, 1, 32'h10);
    tbl[4]  = mk(0, 0, 1, 1, 32'h20, 1, 1, 1, 32'h20);
    tbl[5]  = mk(0, 0, 1, 1, 32'h30, 1, 1, 1, 32'h30);
    tbl[6]  = mk(0, 0, 1, 1, 32'h40, 1, 1, 1, 32'h40);
    tbl[7]  = mk(0, 0, 0, 1, 32'h00, 0, 1, 0, 32'h0);
    tbl[8]  = mk(0, 0, 1, 0, 32'hA1, 1, 1, 1, 32'hA1);
    tbl[9]  = mk(0, 0, 1, 0, 32'hA2, 1, 0, 1, 32'hA1);
    tbl[10] = mk(0, 0, 1, 0, 32'hA3, 1, 0, 1, 32'hA1);
    tbl[11] = mk(0, 0, 1, 1, 32'hA3, 1, 1, 1, 32'hA2);
    tbl[12] = mk(0, 0, 1, 1, 32'hA3, 1, 1, 1, 32'hA3);
    tbl[13] = mk(0, 0, 0, 1, 32'h00, 0, 1, 0, 32'h0);
    tbl[14] = mk(0, 0, 1, 0, 32'hB1, 1, 1, 1, 32'hB1);
    tbl[15] = mk(0, 0, 1, 0, 32'hB2, 1, 0, 1, 32'hB1);
    tbl[16] = mk(0, 1, 1, 0, 32'hB3, 0, 1, 0, 32'h0);
    tbl[17] = mk(0, 0, 0, 1, 32'h00, 0, 1, 0, 32'h0);
    tbl[18] = mk(0, 1, 1, 1, 32'hC1, 0, 1, 0, 32'h0);
    tbl[19] = mk(0, 0, 0, 1, 32'h00, 0, 1, 0, 32'h0);

    for (int i = 0; i < 20; i++) begin
      reset = tbl[i].rst; flush = tbl[i].fl; in_valid = tbl[i].iv;
      out_ready = tbl[i].ordy; ALUResult = tbl[i].alu;
      tick();
      chk($sformatf("tbl%0d out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
      chk($sformatf("tbl%0d in_ready", i), 64'(in_ready), 64'(tbl[i].e_ir));
      if (tbl[i].chk_alu)
        chk($sformatf("tbl%0d out_ALUResult", i), 64'(out_ALUResult), 64'(tbl[i].e_alu));
    end

    // Control pass-through, held stable under backpressure.
    in_valid = 1; out_ready = 0; ALUResult = 32'h77; StoreData = 32'hDEADBEEF;
    Rd = 5'd31; MemWrite = 1; MemRead = 0; RegWrite = 0; MemtoReg = 0;
    tick();
    in_valid = 0; StoreData = 32'h0; Rd = 5'd0; MemWrite = 0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("pass%0d out_valid", c), 64'(out_valid), 64'(1));
      chk($sformatf("pass%0d out_Rd", c), 64'(out_Rd), 64'(31));
      chk($sformatf("pass%0d out_MemWrite", c), 64'(out_MemWrite), 64'(1));
      chk($sformatf("pass%0d out_MemRead", c), 64'(out_MemRead), 64'(0));
      chk($sformatf("pass%0d out_StoreData", c), 64'(out_StoreData), 64'(32'hDEADBEEF));
      chk($sformatf("pass%0d out_ALUResult", c), 64'(out_ALUResult), 64'(32'h77));
      tick();
    end
    out_ready = 1;
    tick();
    chk("pass_drain out_valid", 64'(out_valid), 64'(0));

`ifdef EX_MEM_BRANCH_EN
    in_valid = 1; Branch = 1; ALUResult = 32'h1; BranchPC = 32'h100;
    tick();
    chk("br_taken pulse", 64'(BranchTaken), 64'(1));
    chk("br_target", 64'(BranchTarget), 64'(32'h100));
    in_valid = 0; Branch = 0;
    tick();
    chk("br_taken one_cycle", 64'(BranchTaken), 64'(0));
    in_valid = 1; Branch = 1; ALUResult = 32'h0; BranchPC = 32'h200;
    tick();
    chk("br_not_taken", 64'(BranchTaken), 64'(0));
    in_valid = 0; Branch = 0;
    tick();
    chk("br_not_taken2", 64'(BranchTaken), 64'(0));
`endif

    // Random traffic against a FIFO model: at most two entries, in order.
    reset = 1; flush = 0; in_valid = 0; out_ready = 0;
    tick();
    reset = 0;
    mq.delete();
    begin
      logic        r, f, acc, drn;
      ent_t        e;
`ifdef EX_MEM_BRANCH_EN
      logic        exp_bt;
      logic [31:0] exp_tgt;
      exp_tgt = 32'h0;
`endif
      for (int n = 0; n < 500; n++) begin
        r = ($urandom_range(0, 59) == 0);
        f = ($urandom_range(0, 29) == 0);
        e.alu = $urandom; e.sd = $urandom; e.rd = 5'($urandom);
        e.mr = 1'($urandom); e.mw = 1'($urandom); e.rw = 1'($urandom); e.mtr = 1'($urandom);
        reset = r; flush = f;
        in_valid = ($urandom_range(0, 3) != 0);
        out_ready = 1'($urandom);
        ALUResult = e.alu; StoreData = e.sd; Rd = e.rd;
        MemRead = e.mr; MemWrite = e.mw; RegWrite = e.rw; MemtoReg = e.mtr;
`ifdef EX_MEM_BRANCH_EN
        Branch = 1'($urandom);
        BranchPC = $urandom;
`endif
        acc = in_valid && (mq.size() < 2);
        drn = (mq.size() > 0) && out_ready;
`ifdef EX_MEM_BRANCH_EN
        exp_bt = !r && !f && acc && Branch && e.alu[0];
        if (r) exp_tgt = 32'h0;
        else if (exp_bt) exp_tgt = BranchPC;
`endif
        tick();
        if (r || f) mq.delete();
        else begin
          if (drn) void'(mq.pop_front());
          if (acc) mq.push_back(e);
        end
        chk($sformatf("rnd%0d out_valid", n), 64'(out_valid), 64'(mq.size() > 0));
        chk($sformatf("rnd%0d in_ready", n), 64'(in_ready), 64'(mq.size() < 2));
        if (mq.size() > 0) begin
          chk($sformatf("rnd%0d out_ALUResult", n), 64'(out_ALUResult), 64'(mq[0].alu));
          chk($sformatf("rnd%0d out_StoreData", n), 64'(out_StoreData), 64'(mq[0].sd));
          chk($sformatf("rnd%0d out_ctrl", n),
              64'({out_Rd, out_MemRead, out_MemWrite, out_RegWrite, out_MemtoReg}),
              64'({mq[0].rd, mq[0].mr, mq[0].mw, mq[0].rw, mq[0].mtr}));
        end else if (r) begin
          chk($sformatf("rnd%0d reset_data", n), 64'({out_ALUResult, out_Rd}), 64'(0));
        end
`ifdef EX_MEM_BRANCH_EN
        chk($sformatf("rnd%0d BranchTaken", n), 64'(BranchTaken), 64'(exp_bt));
        chk($sformatf("rnd%0d BranchTarget", n), 64'(BranchTarget), 64'(exp_tgt));
`endif
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_buffer.md
# ex_mem_buffer

Pipeline buffer between the execute stage (ALU) and the memory stage of the RISC-V pipeline. Captures the ALU result, store data, destination register and memory/writeback control bits with a valid/ready handshake. A one-entry skid register makes `in_ready` a pure register output, so a memory-stage stall never creates a combinational path back into execute. Supports a synchronous flush, and optionally resolves branches from the ALU Equal result.

## Interface
- `DATA_WIDTH`, 32, width of ALU result, store data and PC.
- `REG_ADDR_WIDTH`, 5, width of the destination register index.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `flush` input 1: synchronous; discards all buffered entries.
- `in_valid` input 1: execute stage presents an entry.
- `in_ready` output 1: buffer can accept; equals NOT skid_valid.
- `ALUResult` input DATA_WIDTH: ALU output.
- `StoreData` input DATA_WIDTH: forwarded rs2 value for stores.
- `Rd` input REG_ADDR_WIDTH: destination register.
- `MemRead`, `MemWrite`, `RegWrite`, `MemtoReg` input 1 each: control bits.
- `out_valid` output 1: memory stage entry is valid.
- `out_ready` input 1: memory stage consumes the entry this cycle.
- `out_ALUResult`, `out_StoreData`, `out_Rd`, `out_MemRead`, `out_MemWrite`, `out_RegWrite`, `out_MemtoReg` outputs: registered copies of the inputs.

## Operation
- Storage is a main register (drives the `out_*` ports) plus a skid register, each with a valid bit: `main_valid` (= `out_valid`) and `skid_valid`.
- Accept = `in_valid & in_ready`. Drain = `out_valid & out_ready`.
- Per-cycle priority:
  1. `reset`: both valid bits cleared, all data cleared to 0.
  2. `flush`: both valid bits cleared; data regs may hold stale values. Any accept in the same cycle is discarded.
  3. Normal operation:
     - Main empty or draining: main loads the skid entry if `skid_valid`, otherwise the incoming entry on accept.
     - Main loaded from skid while an accept also occurs: the incoming entry goes to skid.
     - Main full and not draining: an accept goes to skid.
- Skid is written only when `skid_valid`=0. Skid is cleared when it moves to main and no new accept refills it.
- `in_ready` = NOT `skid_valid`. At most 2 entries are held. Entries are never reordered or dropped except by flush or reset.
- While `out_valid`=1 and `out_ready`=0, every `out_*` port is held stable.
- Fields are passed unmodified; no arithmetic on data.

## Timing
- Reset values: `out_valid`=0, all `out_*` data/control=0, `in_ready`=1 (skid empty). `BranchTaken`=0 and `BranchTarget`=0 when branch support is compiled in.
- Latency: an entry accepted at edge N appears on the `out_*` ports after edge N (visible in cycle N+1). A skid entry moves to main on the edge after the drain.
- Throughput: 1 entry/cycle while `out_ready`=1.
- Sequence with `out_ready` low and `in_valid` high: first accept fills main, second fills skid, then `in_ready` drops to 0.
- Recovery: after `out_ready` rises, `in_ready` returns to 1 one cycle later.
- Flush or reset mid-stall: `out_valid`=0 and `in_ready`=1 on the next cycle.

## Configuration
- `EX_MEM_BRANCH_EN` defined:
  - Adds inputs `Branch` (1) and `BranchPC` (DATA_WIDTH), and outputs `BranchTaken` (1) and `BranchTarget` (DATA_WIDTH).
  - On accept of an entry with `Branch`=1 and `ALUResult[0]`=1, `BranchTaken` pulses high for exactly one cycle after the edge, with `BranchTarget`=`BranchPC` registered.
  - A flush or reset in the accept cycle suppresses the pulse.
  - `BranchTaken` follows accept, not drain: it is not held during stalls.
- `EX_MEM_BRANCH_EN` undefined: these ports and their logic do not exist. Branch resolution is done elsewhere.

## Test plan
- Reset: hold `reset` for 2 cycles with `in_valid`=1 and `ALUResult`=0x55 -> `out_valid`=0, `out_ALUResult`=0, `in_ready`=1 after release.
- Streaming: 4 back-to-back entries 0x10, 0x20, 0x30, 0x40 with `out_ready`=1 -> same values on `out_ALUResult` on consecutive cycles, 1-cycle latency, `in_ready` stays 1.
- Backpressure: `out_ready`=0 while sending 0xA1, 0xA2, 0xA3 -> main=0xA1, skid=0xA2, `in_ready`=0, 0xA3 held upstream. Raise `out_ready` -> outputs 0xA1, 0xA2, 0xA3 in order, none lost.
- Flush: flush while main and skid are full and `in_valid`=1 -> next cycle `out_valid`=0, `in_ready`=1, and the entry offered in the flush cycle is absent.
- Control pass-through: `Rd`=5'd31, `MemWrite`=1, `StoreData`=0xDEADBEEF -> identical values on the `out_*` ports one cycle later, held while `out_ready`=0.
- With `EX_MEM_BRANCH_EN`: `Branch`=1, `ALUResult`=1, `BranchPC`=0x100 -> `BranchTaken`=1 for exactly one cycle with `BranchTarget`=0x100. With `ALUResult`=0 -> `BranchTaken` stays 0.
